// File: rtl/square_wave_period_meter.sv
// Square-wave period / high-time meter with hysteresis edge detection and lock timeout.
// Optional SQUARE_WAVE_METER_AVG_EN: period reports the mean of the last 4 measurements.
module square_wave_period_meter #(
  parameter int unsigned CLOCK_RATE     = 50000000,
  parameter int          THRESHOLD_HIGH = 12288,
  parameter int          THRESHOLD_LOW  = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic        [31:0] period,
  output logic        [31:0] high_time,
  output logic               valid,
  output logic               locked
);

  localparam int unsigned CNT_W = 32;
  localparam logic signed [15:0] TH_HI   = 16'(THRESHOLD_HIGH);
  localparam logic signed [15:0] TH_LO   = 16'(THRESHOLD_LOW);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  // Reject parameter sets that make the hysteresis band or clock meaningless
  if (CLOCK_RATE == 0 || THRESHOLD_LOW >= THRESHOLD_HIGH) begin : g_param_check
    $error("square_wave_period_meter: bad CLOCK_RATE or thresholds");
  end

  typedef enum logic {WAIT_EDGE, MEASURE} state_t;

  state_t           state;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cap;
  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             timeout_c;

  always_comb begin
    rise_c    = 1'b0;
    fall_c    = 1'b0;
    cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    timeout_c = (cnt >= TIMEOUT);
    if (audio_clk_en) begin
      rise_c = !level && (in >= TH_HI);
      fall_c =  level && (in <= TH_LO);
    end
  end

  // Hysteresis level, frozen while the sample strobe is low
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      level <= 1'b0;
    end else if (rise_c) begin
      level <= 1'b1;
    end else if (fall_c) begin
      level <= 1'b0;
    end
  end

`ifdef SQUARE_WAVE_METER_AVG_EN
  logic [CNT_W-1:0]   hist [4];
  logic [CNT_W+1:0]   hist_sum;
  logic [2:0]         meas_cnt;
  logic [CNT_W+1:0]   sum_next_c;

  assign sum_next_c = hist_sum - (CNT_W+2)'(hist[3]) + (CNT_W+2)'(cnt);
`endif

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state     <= WAIT_EDGE;
      cnt       <= '0;
      hi_cap    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
`ifdef SQUARE_WAVE_METER_AVG_EN
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      hist_sum  <= '0;
      meas_cnt  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_EDGE: begin
          if (rise_c) begin
            state  <= MEASURE;
            cnt    <= CNT_W'(1);
            hi_cap <= '0;
`ifdef SQUARE_WAVE_METER_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            hist_sum <= '0;
            meas_cnt <= '0;
`endif
          end
        end
        MEASURE: begin
          cnt <= cnt_inc_c;
          // A rising edge on the timeout cycle still counts as a measurement
          if (rise_c) begin
            cnt <= CNT_W'(1);
`ifdef SQUARE_WAVE_METER_AVG_EN
            hist[0] <= cnt;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            hist_sum <= sum_next_c;
            meas_cnt <= (meas_cnt == 3'd4) ? meas_cnt : meas_cnt + 3'd1;
            if (meas_cnt >= 3'd3) begin
              period    <= sum_next_c[CNT_W+1:2];
              high_time <= hi_cap;
              valid     <= 1'b1;
              locked    <= 1'b1;
            end
`else
            period    <= cnt;
            high_time <= hi_cap;
            valid     <= 1'b1;
            locked    <= 1'b1;
`endif
          end else if (timeout_c) begin
            state     <= WAIT_EDGE;
            cnt       <= '0;
            hi_cap    <= '0;
            period    <= '0;
            high_time <= '0;
            locked    <= 1'b0;
`ifdef SQUARE_WAVE_METER_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            hist_sum <= '0;
            meas_cnt <= '0;
`endif
          end else if (fall_c) begin
            hi_cap <= cnt;
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Randomized self-checking bench for square_wave_period_meter against a timestamp-based model.
module tb_square_wave_period_meter;

  localparam int TH_HI = 12288;
  localparam int TH_LO = 4096;
  localparam int TO    = 5000;

  logic               clk;
  logic               I_RSTn;
  logic               audio_clk_en;
  logic signed [15:0] din;
  logic        [31:0] period;
  logic        [31:0] high_time;
  logic               valid;
  logic               locked;

  square_wave_period_meter #(
    .CLOCK_RATE(50000000), .THRESHOLD_HIGH(TH_HI), .THRESHOLD_LOW(TH_LO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .in(din),
    .period(period), .high_time(high_time), .valid(valid), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges are timestamped in clk cycles; period is the difference of timestamps.
  longint cyc = 0;
  longint t_rise;
  longint v_cyc;
  int     n_valid_seen;
  bit     m_lvl, m_armed, m_valid, m_locked;
  int unsigned m_hi, m_period, m_high;
  int unsigned m_hist[$];

  task automatic m_reset();
    m_lvl = 0; m_armed = 0; m_valid = 0; m_locked = 0;
    m_hi = 0; m_period = 0; m_high = 0; m_hist.delete();
  endtask

  task automatic m_measure(input int unsigned p);
`ifdef SQUARE_WAVE_METER_AVG_EN
    longint s = 0;
    m_hist.push_back(p);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    if (m_hist.size() == 4) begin
      foreach (m_hist[i]) s += m_hist[i];
      m_period = 32'(s / 4); m_high = m_hi; m_valid = 1; m_locked = 1;
    end
`else
    m_period = p; m_high = m_hi; m_valid = 1; m_locked = 1;
`endif
  endtask

  task automatic m_step(input bit en, input int x);
    bit rise = en && !m_lvl && (x >= TH_HI);
    bit fall = en &&  m_lvl && (x <= TH_LO);
    if (rise) m_lvl = 1;
    if (fall) m_lvl = 0;
    m_valid = 0;
    if (m_armed) begin
      if (rise) begin
        m_measure(32'(cyc - t_rise));
        t_rise = cyc;
      end else if (cyc - t_rise >= TO) begin
        m_armed = 0; m_locked = 0; m_period = 0; m_high = 0; m_hi = 0; m_hist.delete();
      end else if (fall) begin
        m_hi = 32'(cyc - t_rise);
      end
    end else if (rise) begin
      m_armed = 1; t_rise = cyc; m_hi = 0; m_hist.delete();
    end
  endtask

  // One clk cycle: drive inputs, advance the model, compare after the edge
  task automatic tick(input bit en, input int x);
    audio_clk_en = en;
    din = 16'(x);
    m_step(en, x);
    @(posedge clk); #1;
    cyc++;
    if (valid) begin n_valid_seen++; v_cyc = cyc; end
    chk("valid", 32'(valid), 32'(m_valid));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("period", period, m_period);
    chk("high_time", high_time, m_high);
  endtask

  task automatic do_reset();
    audio_clk_en = 1'b0;
    I_RSTn = 1'b0;
    #2;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_locked", 32'(locked), 0);
    m_reset();
    @(posedge clk); #1;
    cyc++;
    I_RSTn = 1'b1;
  endtask

  // Square wave: hi_en/lo_en strobes per half, strobe every gap clks
  task automatic sq(input int n, input int gap, input int hi_en, input int lo_en);
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < hi_en; k++) begin
        tick(1, 16384);
        for (int g = 1; g < gap; g++) tick(0, int'($urandom_range(65535)) - 32768);
      end
      for (int k = 0; k < lo_en; k++) begin
        tick(1, 0);
        for (int g = 1; g < gap; g++) tick(0, int'($urandom_range(65535)) - 32768);
      end
    end
  endtask

`ifdef SQUARE_WAVE_METER_AVG_EN
  localparam int LOCK_N = 5;
`else
  localparam int LOCK_N = 3;
`endif

  initial begin
    int nv0;
    bit dropped;
    I_RSTn = 1'b1; audio_clk_en = 1'b0; din = '0;
    m_reset();
    n_valid_seen = 0;
    #1;
    do_reset();

    // Nominal 2000-clk square wave, 50% duty
    nv0 = n_valid_seen;
    sq(5, 100, 10, 10);
    chk("nom_period", period, 2000);
    chk("nom_high", high_time, 1000);
    chk("nom_locked", 32'(locked), 1);
`ifdef SQUARE_WAVE_METER_AVG_EN
    chk("nom_nvalid", 32'(n_valid_seen - nv0), 1);
`else
    chk("nom_nvalid", 32'(n_valid_seen - nv0), 4);
`endif

    // Sub-threshold chatter never produces an edge
    do_reset();
    nv0 = n_valid_seen;
    for (int i = 0; i < 1000; i++) tick(1, (i % 2) ? 5000 : 8000);
    chk("chatter_nvalid", 32'(n_valid_seen - nv0), 0);
    chk("chatter_locked", 32'(locked), 0);

    // Timeout exactly TO clks after the last edge
    do_reset();
    sq(LOCK_N, 100, 10, 10);
    tick(1, 16384);
    for (int k = 1; k < 10; k++) tick(0, 0);
    chk("to_locked_pre", 32'(locked), 1);
    nv0 = n_valid_seen;
    dropped = 0;
    for (int i = 0; i < TO + 1000 && !dropped; i++) begin
      tick(1, 0);
      if (!locked) dropped = 1;
    end
    chk("to_dropped", 32'(dropped), 1);
    chk("to_delay", 32'(cyc - v_cyc), 32'(TO));
    chk("to_period", period, 0);
    chk("to_high", high_time, 0);
    chk("to_nvalid", 32'(n_valid_seen - nv0), 0);

    // Reset mid-period while locked; the first edge afterwards only arms
    do_reset();
    sq(LOCK_N, 100, 10, 10);
    for (int k = 0; k < 300; k++) tick(k % 100 == 0, 16384);
    chk("mr_locked_pre", 32'(locked), 1);
    do_reset();
    nv0 = n_valid_seen;
    sq(2, 100, 10, 10);
`ifdef SQUARE_WAVE_METER_AVG_EN
    chk("mr_nvalid", 32'(n_valid_seen - nv0), 0);
`else
    chk("mr_nvalid", 32'(n_valid_seen - nv0), 1);
    chk("mr_period", period, 2000);
`endif

    // Randomized waves with noise between thresholds and occasional long gaps
    do_reset();
    for (int s = 0; s < 30; s++) begin
      int gap = int'($urandom_range(8, 1));
      int hn  = int'($urandom_range(30, 1));
      int ln  = ($urandom_range(9) == 0) ? 700 : int'($urandom_range(30, 1));
      for (int k = 0; k < hn; k++) begin
        tick(1, ($urandom_range(7) == 0) ? int'($urandom_range(TH_HI - 1, TH_LO + 1))
                                         : int'($urandom_range(32767, TH_HI)));
        for (int g = 1; g < gap; g++) tick(0, int'($urandom_range(65535)) - 32768);
      end
      for (int k = 0; k < ln; k++) begin
        tick(1, ($urandom_range(7) == 0) ? int'($urandom_range(TH_HI - 1, TH_LO + 1))
                                         : int'($urandom_range(TH_LO + 32768)) - 32768);
        for (int g = 1; g < gap; g++) tick(0, int'($urandom_range(65535)) - 32768);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/square_wave_period_meter.md
SQUARE_WAVE_PERIOD_METER -- requirements
Module: square_wave_period_meter

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50000000, system clock frequency in Hz (informational, sizing only).
REQ-002 SHALL have parameter THRESHOLD_HIGH, default 12288, signed input level that registers a rising edge.
REQ-003 SHALL have parameter THRESHOLD_LOW, default 4096, signed input level that registers a falling edge; THRESHOLD_LOW < THRESHOLD_HIGH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50000000, clk cycles without a rising edge before lock is dropped.
REQ-005 clk  input  1  system clock; the single clock domain.
REQ-006 I_RSTn  input  1  reset, asynchronous assert, active-low.
REQ-007 audio_clk_en  input  1  sample strobe; in is evaluated only when high.
REQ-008 in  input  16 signed  audio sample, e.g. output of invertor_square_wave_oscilator.
REQ-009 period  output  32  clk cycles between the last two rising edges.
REQ-010 high_time  output  32  clk cycles from the last rising edge to the following falling edge.
REQ-011 valid  output  1  one-clk pulse when period and high_time update.
REQ-012 locked  output  1  high while at least one valid measurement stands and no timeout has occurred.

Function
REQ-013 SHALL keep a hysteresis level bit: on an audio_clk_en cycle, if level=0 and in >= THRESHOLD_HIGH, set level=1 (rising event); if level=1 and in <= THRESHOLD_LOW, clear level=0 (falling event); comparisons signed.
REQ-014 SHALL implement states WAIT_EDGE and MEASURE; WAIT_EDGE is the reset state.
REQ-015 WAIT_EDGE: rising event -> MEASURE, cnt <= 1; falling events are ignored.
REQ-016 MEASURE: cnt increments by 1 every clk cycle, saturating at 2^32-1.
REQ-017 MEASURE, falling event: hi_cap <= cnt.
REQ-018 MEASURE, rising event: period <= cnt, high_time <= hi_cap, valid <= 1 for one clk, locked <= 1, cnt <= 1; so period equals the exact clk distance between the two event cycles.
REQ-019 Output latency: period, high_time, valid, locked change on the clk edge that samples the event cycle (registered, 1 clk).
REQ-020 Timeout: in MEASURE, when cnt reaches TIMEOUT_CYCLES without a rising event -> WAIT_EDGE, locked <= 0, period <= 0, high_time <= 0, no valid pulse.
REQ-021 A rising event on the same cycle cnt reaches TIMEOUT_CYCLES SHALL be treated as a normal measurement (edge wins).
REQ-022 If no falling event occurs within a period, high_time SHALL report the previous hi_cap value, cleared to 0 on entry to MEASURE from WAIT_EDGE.
REQ-023 audio_clk_en low SHALL freeze level; counters continue.

Reset
REQ-024 On I_RSTn low: state=WAIT_EDGE, level=0, cnt=0, hi_cap=0, period=0, high_time=0, valid=0, locked=0, immediately and asynchronously.
REQ-025 Reset mid-measurement SHALL discard the partial period; the first post-reset rising event only arms MEASURE.

Configuration
REQ-026 Macro SQUARE_WAVE_METER_AVG_EN defined: period SHALL output the mean of the last 4 measured periods (4-entry history sum >> 2); valid and locked assert only from the 4th measurement after entering MEASURE; history clears on reset and timeout.
REQ-027 Macro undefined: no history logic; period is the single latest measurement per REQ-018.

Verification
REQ-028 Enable every 100 clks; in=16384 for 10 enables, 0 for 10, repeated -> from the 2nd rising edge valid pulses, period=2000, high_time=1000, locked=1.
REQ-029 in alternating 8000/5000 around zero-crossing pattern never exceeding THRESHOLD_HIGH -> no valid, locked=0.
REQ-030 TIMEOUT_CYCLES=5000, lock with period 2000, then hold in=0 -> exactly 5000 clks after last edge locked=0, period=0, high_time=0, no valid.
REQ-031 Assert I_RSTn low mid-period while locked -> outputs zero at once; after release, first edge gives no valid, second gives correct period.
REQ-032 With SQUARE_WAVE_METER_AVG_EN, periods 2000, 2000, 2400, 2400 -> first valid after 4th measurement, period=2200.
